arm_block_xfer_seq: RTL and testbench

- Sequencer for ARM block data transfer (LDM/STM), driven from the decoder's `block` fields (P, U, S, W, reg_list) plus Rn and the load/store bit.
- Walks reg_list lowest-to-highest, issues one word transfer per register over a req/ack memory handshake, drives the register-file port, then performs base writeback.
- Sits between the control unit and the memory interface / register file. The control unit stalls the pipeline while `busy_o`=1.

---
 rtl/cpu_decoder_types_pkg.sv | 26 ++
 rtl/arm_block_xfer_seq_if.sv | 16 +
 rtl/lowest_set_bit16.sv | 17 +
 rtl/arm_block_xfer_seq.sv | 186 ++++++++++++++++++
 tb/tb_arm_block_xfer_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_decoder_types_pkg.sv
// Shared decoder types for the block-transfer sequencer: FSM states, offset flag, word size.
// Build option ARM_BLOCK_EMPTY_LIST_QUIRK_EN is consumed by arm_block_xfer_seq.
package cpu_decoder_types_pkg;

  typedef enum logic {
    POST_OFFSET = 1'b0,
    PRE_OFFSET  = 1'b1
  } pre_post_offset_flag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } block_seq_state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/arm_block_xfer_seq_if.sv
// Word memory bus between the block-transfer sequencer (master) and memory (slave).
// Handshake: master raises mem_req with mem_we/mem_addr/mem_wdata and holds them stable until
// a cycle with mem_ack=1; that cycle completes the transfer (mem_rdata valid for reads).
interface arm_block_xfer_seq_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lowest_set_bit16.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit vector.
module lowest_set_bit16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arm_block_xfer_seq.sv
// LDM/STM sequencer: walks reg_list low-to-high, one bus word per register, then base writeback.
// Build option ARM_BLOCK_EMPTY_LIST_QUIRK_EN: an empty list transfers R15 only with n=16 offsets.
module arm_block_xfer_seq
  import cpu_decoder_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  load_i,
  input  logic                  pre_i,
  input  logic                  up_i,
  input  logic                  s_bit_i,
  input  logic                  wb_i,
  input  logic [3:0]            rn_i,
  input  logic [15:0]           reg_list_i,
  input  logic [ADDR_W-1:0]     base_i,
  output logic                  busy_o,
  output logic                  done_o,
  arm_block_xfer_seq_if.master  mem,
  output logic [3:0]            rf_raddr_o,
  input  logic [ADDR_W-1:0]     rf_rdata_i,
  output logic                  rf_we_o,
  output logic [3:0]            rf_waddr_o,
  output logic [ADDR_W-1:0]     rf_wdata_o,
  output logic                  user_bank_o,
  output logic                  pc_loaded_o,
  output logic                  spsr_restore_o,
  output block_seq_state_t      state_o
);

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

  block_seq_state_t      state_q, state_d;
  logic [15:0]           list_q, list_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     final_q, final_d;
  logic                  load_q, load_d, s_q, s_d, wb_q, wb_d;
  logic                  bit15_q, bit15_d, rn_hit_q, rn_hit_d;
  logic [3:0]            rn_q, rn_d;

  logic [15:0]           list_eff;
  logic [4:0]            n_eff;
  logic [ADDR_W-1:0]     span, start_addr, final_base;
  pre_post_offset_flag_t pre_e;
  logic [3:0]            cur;
  logic                  cur_valid;

  lowest_set_bit16 u_lsb (
    .vec_i   (list_q),
    .idx_o   (cur),
    .valid_o (cur_valid)
  );

  // Effective list and address span of the instruction being offered on the inputs.
  always_comb begin
    list_eff = reg_list_i;
    n_eff    = popcount16(reg_list_i);
`ifdef ARM_BLOCK_EMPTY_LIST_QUIRK_EN
    if (reg_list_i == 16'd0) begin
      list_eff = 16'h8000;
      n_eff    = 5'd16;
    end
`endif
    pre_e = pre_post_offset_flag_t'(pre_i);
    span  = ADDR_W'({n_eff, 2'b00});
    case ({up_i, pre_e})
      {1'b1, POST_OFFSET}: start_addr = base_i;
      {1'b1, PRE_OFFSET}:  start_addr = base_i + WORD;
      {1'b0, POST_OFFSET}: start_addr = base_i - span + WORD;
      default:             start_addr = base_i - span;
    endcase
    final_base = up_i ? (base_i + span) : (base_i - span);
  end

  always_comb begin
    state_d        = state_q;
    list_d         = list_q;
    addr_d         = addr_q;
    final_d        = final_q;
    load_d         = load_q;
    s_d            = s_q;
    wb_d           = wb_q;
    rn_d           = rn_q;
    bit15_d        = bit15_q;
    rn_hit_d       = rn_hit_q;
    done_o         = 1'b0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    rf_raddr_o     = 4'd0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = 4'd0;
    rf_wdata_o     = '0;
    user_bank_o    = 1'b0;
    pc_loaded_o    = 1'b0;
    spsr_restore_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          list_d   = list_eff;
          addr_d   = start_addr;
          final_d  = final_base;
          load_d   = load_i;
          s_d      = s_bit_i;
          wb_d     = wb_i;
          rn_d     = rn_i;
          bit15_d  = list_eff[15];
          rn_hit_d = list_eff[rn_i];
          state_d  = XFER;
        end
      end
      XFER: begin
        if (cur_valid) begin
          mem.mem_req   = 1'b1;
          mem.mem_we    = !load_q;
          mem.mem_addr  = ALIGN_ADDR ? (addr_q & ~ADDR_W'(3)) : addr_q;
          mem.mem_wdata = rf_rdata_i;
          rf_raddr_o    = cur;
          user_bank_o   = s_q && !(load_q && bit15_q);
          if (mem.mem_ack) begin
            if (load_q) begin
              rf_we_o    = 1'b1;
              rf_waddr_o = cur;
              rf_wdata_o = mem.mem_rdata;
            end
            list_d = list_q & ~(16'd1 << cur);
            addr_d = addr_q + WORD;
            if (list_d == 16'd0)
              state_d = (wb_q && !(load_q && rn_hit_q)) ? WB : DONE;
          end
        end else begin
          // Only an empty list lands here: one idle cycle, no bus traffic, no writeback.
          state_d = DONE;
        end
      end
      WB: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = rn_q;
        rf_wdata_o = final_q;
        state_d    = DONE;
      end
      DONE: begin
        done_o         = 1'b1;
        pc_loaded_o    = load_q && bit15_q;
        spsr_restore_o = load_q && s_q && bit15_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      list_q   <= '0;
      addr_q   <= '0;
      final_q  <= '0;
      load_q   <= 1'b0;
      s_q      <= 1'b0;
      wb_q     <= 1'b0;
      rn_q     <= 4'd0;
      bit15_q  <= 1'b0;
      rn_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      addr_q   <= addr_d;
      final_q  <= final_d;
      load_q   <= load_d;
      s_q      <= s_d;
      wb_q     <= wb_d;
      rn_q     <= rn_d;
      bit15_q  <= bit15_d;
      rn_hit_q <= rn_hit_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_arm_block_xfer_seq.sv
// Scoreboard bench for arm_block_xfer_seq: a reference model predicts bus beats, rf writes and
// the done pulse; a negedge monitor pops and compares. Honours ARM_BLOCK_EMPTY_LIST_QUIRK_EN.
`timescale 1ns/1ps
module tb_arm_block_xfer_seq;

  localparam int W = 73;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT hookup ----------------
  logic        start_i, load_i, pre_i, up_i, s_bit_i, wb_i;
  logic [3:0]  rn_i;
  logic [15:0] reg_list_i;
  logic [31:0] base_i;
  logic        busy_o, done_o, rf_we_o, user_bank_o, pc_loaded_o, spsr_restore_o;
  logic [3:0]  rf_raddr_o, rf_waddr_o;
  logic [31:0] rf_rdata_i, rf_wdata_o;
  logic [1:0]  state_o;

  arm_block_xfer_seq_if #(.ADDR_W(32)) mem_if ();

  arm_block_xfer_seq #(.ADDR_W(32), .ALIGN_ADDR(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .load_i         (load_i),
    .pre_i          (pre_i),
    .up_i           (up_i),
    .s_bit_i        (s_bit_i),
    .wb_i           (wb_i),
    .rn_i           (rn_i),
    .reg_list_i     (reg_list_i),
    .base_i         (base_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .mem            (mem_if.master),
    .rf_raddr_o     (rf_raddr_o),
    .rf_rdata_i     (rf_rdata_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .user_bank_o    (user_bank_o),
    .pc_loaded_o    (pc_loaded_o),
    .spsr_restore_o (spsr_restore_o),
    .state_o        (state_o)
  );

  // ---------------- environment: register file and memory contents ----------------
  logic [31:0] rf_salt = 32'h0;
  assign rf_rdata_i = {8{rf_raddr_o}} ^ rf_salt;

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    return {8{r}} ^ rf_salt;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  int wait_cfg = 0;
  int wcnt = 0;

  // Memory responder: ack after wait_cfg idle cycles of a held request.
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_if.mem_req && rst_n) begin
        if (wcnt >= wait_cfg) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_val(mem_if.mem_addr);
          wcnt = 0;
        end else begin
          mem_if.mem_ack   = 1'b0;
          mem_if.mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem_if.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  logic exp_ub = 1'b0;

  function automatic logic [W-1:0] mk(input logic [1:0] kind, input logic [3:0] a,
                                      input logic [2:0] f, input logic [31:0] ad,
                                      input logic [31:0] d);
    return {kind, a, f, ad, d};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string nm, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event %h, nothing expected (t=%0t)", nm, act, $time);
    end else begin
      chk(nm, act, exp_q.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_wait) begin
        chk("req_hold", W'(mem_if.mem_req), W'(1'b1));
        chk("addr_hold", W'(mem_if.mem_addr), W'(prev_addr));
      end
      if (mem_if.mem_req) chk("user_bank", W'(user_bank_o), W'(exp_ub));
      if (mem_if.mem_req && mem_if.mem_ack)
        sb_pop("bus", mk(2'd0, 4'd0, {mem_if.mem_we, user_bank_o, 1'b0}, mem_if.mem_addr,
                         mem_if.mem_we ? mem_if.mem_wdata : 32'h0));
      if (rf_we_o)
        sb_pop("rf_write", mk(2'd1, rf_waddr_o, {user_bank_o, 2'b00}, 32'h0, rf_wdata_o));
      if (done_o)
        sb_pop("done", mk(2'd2, 4'd0, {pc_loaded_o, spsr_restore_o, 1'b0}, 32'h0,
                          32'(cyc - start_cyc)));
      prev_wait = mem_if.mem_req && !mem_if.mem_ack;
      prev_addr = mem_if.mem_addr;
    end else begin
      prev_wait = 1'b0;
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic issue(input bit ld, input bit pre, input bit up, input bit s, input bit wb,
                       input logic [3:0] rn, input logic [15:0] lst, input logic [31:0] base);
    logic [15:0] eff;
    int          n, nx, k, lat;
    logic [31:0] a, fin, ba;
    bit          wbx;
    eff = lst;
    n   = $countones(lst);
`ifdef ARM_BLOCK_EMPTY_LIST_QUIRK_EN
    if (lst == 16'h0) begin
      eff = 16'h8000;
      n   = 16;
    end
`endif
    nx  = $countones(eff);
    a   = up ? base + (pre ? 32'd4 : 32'd0) : base - 32'(4 * n) + (pre ? 32'd0 : 32'd4);
    fin = up ? base + 32'(4 * n) : base - 32'(4 * n);
    exp_ub = s && !(ld && eff[15]);
    k = 0;
    for (int r = 0; r < 16; r++) begin
      if (eff[r]) begin
        ba = (a + 32'(4 * k)) & ~32'd3;
        exp_q.push_back(mk(2'd0, 4'd0, {!ld, exp_ub, 1'b0}, ba, ld ? 32'h0 : rf_val(4'(r))));
        if (ld) exp_q.push_back(mk(2'd1, 4'(r), {exp_ub, 2'b00}, 32'h0, mem_val(ba)));
        k++;
      end
    end
    wbx = wb && (eff != 16'h0) && !(ld && eff[rn]);
    if (wbx) exp_q.push_back(mk(2'd1, rn, 3'b000, 32'h0, fin));
    lat = (eff == 16'h0) ? 2 : nx * (wait_cfg + 1) + (wbx ? 1 : 0) + 1;
    exp_q.push_back(mk(2'd2, 4'd0, {ld && eff[15], ld && s && eff[15], 1'b0}, 32'h0, 32'(lat)));

    load_i = ld; pre_i = pre; up_i = up; s_bit_i = s; wb_i = wb;
    rn_i = rn; reg_list_i = lst; base_i = base;
    start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Wait for the scoreboard to empty; optionally throw ignored start pulses while busy.
  task automatic drain(input bit poke);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      if (poke) begin
        start_i    = busy_o && ($urandom_range(0, 2) == 0);
        load_i     = 1'($urandom);
        reg_list_i = 16'($urandom);
        base_i     = $urandom;
        rn_i       = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"},   W'(busy_o),         W'(1'b0));
    chk({nm, "_done"},   W'(done_o),         W'(1'b0));
    chk({nm, "_req"},    W'(mem_if.mem_req), W'(1'b0));
    chk({nm, "_we"},     W'(mem_if.mem_we),  W'(1'b0));
    chk({nm, "_addr"},   W'(mem_if.mem_addr), W'(32'h0));
    chk({nm, "_wdata"},  W'(mem_if.mem_wdata), W'(32'h0));
    chk({nm, "_rf_we"},  W'(rf_we_o),        W'(1'b0));
    chk({nm, "_raddr"},  W'(rf_raddr_o),     W'(4'h0));
    chk({nm, "_waddr"},  W'(rf_waddr_o),     W'(4'h0));
    chk({nm, "_rwdata"}, W'(rf_wdata_o),     W'(32'h0));
    chk({nm, "_ubank"},  W'(user_bank_o),    W'(1'b0));
    chk({nm, "_pcld"},   W'(pc_loaded_o),    W'(1'b0));
    chk({nm, "_spsr"},   W'(spsr_restore_o), W'(1'b0));
    chk({nm, "_state"},  W'(state_o),        W'(2'd0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start_i = 1'b0; load_i = 1'b0; pre_i = 1'b0; up_i = 1'b0; s_bit_i = 1'b0; wb_i = 1'b0;
    rn_i = 4'd0; reg_list_i = 16'h0; base_i = 32'h0;
    rf_salt = 32'hC0DE_0000;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // STMIA R5!, {R1-R3}
    wait_cfg = 0;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h000E, 32'h0300_0000);
    drain(1'b0);
    // LDMDB R6, {R0,R15}
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'h8001, 32'h0300_0100);
    drain(1'b0);
    // LDMIA R2!, {R1,R2}: base in list, writeback suppressed
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0006, 32'h0300_0200);
    drain(1'b0);
    // STMDA with Rn in list: original base stored, then writeback
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 16'h0030, 32'h0300_0400);
    drain(1'b0);
    // Wait states with ignored start pulses
    wait_cfg = 3;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 16'h0003, 32'h0300_0300);
    drain(1'b1);
    wait_cfg = 0;
    // LDM with S and R15 (exception return), then STM with S (user bank)
    issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd13, 16'h8010, 32'h0300_0500);
    drain(1'b0);
    issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 16'h4C01, 32'h0300_0600);
    drain(1'b0);

    // Reset during the second beat of a 4-register STM
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'h00F0, 32'h0400_0000);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_quiet("abort");
    chk("abort_pending", W'(exp_q.size()), W'(5));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Empty list
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0000, 32'h0500_0000);
    drain(1'b0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0000, 32'h0500_0100);
    drain(1'b0);

    // Randomized instructions
    for (int t = 0; t < 30; t++) begin
      logic [15:0] lst;
      lst = 16'($urandom);
      if ($urandom_range(0, 2) == 0) lst = lst & 16'($urandom);
      wait_cfg = $urandom_range(0, 2);
      rf_salt  = $urandom;
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), lst, $urandom);
      drain(1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
